// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access widths, FSM states, request record.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmem_pkg;

    // Access width encoding as seen on req_width_i
    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10,
        WIDTH_RSVD = 2'b11
    } width_e;

    // Responder FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Countdown width; covers LATENCY-1 for LATENCY up to 15
    localparam int CNT_W = 4;

    // One captured memory request
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        width_e      width;
        logic        write;
        logic        sign_ext;
    } req_t;

    // Natural alignment check; reserved width is flagged separately
    function automatic logic is_misaligned(input width_e width, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (width)
            WIDTH_HALF: bad = lane[0];
            WIDTH_WORD: bad = |lane;
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: merges store data into a word and extracts/extends load data.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [1:0]  lane,
    input  width_e      width,
    input  logic [31:0] wdata,
    input  logic        sign_ext,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_view;
    logic [31:0] half_view;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_sh   = {lane, 3'b000};
    assign half_sh   = {lane[1], 4'b0000};
    assign byte_view = old_word >> byte_sh;
    assign half_view = old_word >> half_sh;
    assign byte_val  = byte_view[7:0];
    assign half_val  = half_view[15:0];

    // Store merge keeps untouched lanes; load extract right-aligns and extends
    always_comb begin
        merged_word = old_word;
        load_data   = '0;
        case (width)
            WIDTH_BYTE: begin
                merged_word = (old_word & ~(32'h0000_00FF << byte_sh))
                            | ({24'h0, wdata[7:0]} << byte_sh);
                load_data   = {{24{sign_ext & byte_val[7]}}, byte_val};
            end
            WIDTH_HALF: begin
                merged_word = (old_word & ~(32'h0000_FFFF << half_sh))
                            | ({16'h0, wdata[15:0]} << half_sh);
                load_data   = {{16{sign_ext & half_val[15]}}, half_val};
            end
            WIDTH_WORD: begin
                merged_word = wdata;
                load_data   = old_word;
            end
            default: begin
                merged_word = old_word;
                load_data   = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed LATENCY from accept to response valid.
// Latency: rsp_valid_o rises LATENCY cycles after the accept cycle (BUSY lasts LATENCY-1 cycles).
// Backpressure: response held stable until rsp_ready_i; no new request accepted until the cycle after.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_width_i,
    input  logic        req_write_i,
    input  logic        req_sign_extend_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int             IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             run_q;
    logic             accept;
    logic             enter_resp;
    req_t             req_in;
    req_t             req_q;
    req_t             req_cur;
    logic             out_of_range;
    logic             access_err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic [31:0]      merged_word;
    logic [31:0]      load_data;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_in = '{addr:     req_addr_i,
                      wdata:    req_wdata_i,
                      width:    width_e'(req_width_i),
                      write:    req_write_i,
                      sign_ext: req_sign_extend_i};

    // run_q keeps ready low while in reset and until the first edge after release
    assign req_ready_o = run_q && (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign accept      = req_valid_i && req_ready_o;

    // With LATENCY=1 the commit edge is the accept edge, so use live inputs while idle
    assign req_cur = (state_q == ST_IDLE) ? req_in : req_q;

    assign out_of_range = ({2'b00, req_cur.addr[31:2]} >= 32'(DEPTH_WORDS));
    assign access_err   = (req_cur.width == WIDTH_RSVD)
                        || is_misaligned(req_cur.width, req_cur.addr[1:0])
                        || out_of_range;
    assign idx          = req_cur.addr[IDX_W+1:2];
    assign rd_word      = out_of_range ? 32'h0 : mem[idx];

    mem_lane_align u_lane_align (
        .old_word    (rd_word),
        .lane        (req_cur.addr[1:0]),
        .width       (req_cur.width),
        .wdata       (req_cur.wdata),
        .sign_ext    (req_cur.sign_ext),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    // Next-state and countdown; enter_resp marks the commit/sample edge
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = LAT_M1;
                    if (LAT_M1 == '0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                cnt_d = '0;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, countdown, captured request and response registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            if (accept) begin
                req_q <= req_in;
            end
            if (enter_resp) begin
                err_q   <= access_err;
                rdata_q <= (access_err || req_cur.write) ? 32'h0 : load_data;
            end
        end
    end

    // Storage is not reset; stores land only on a clean commit edge
    always_ff @(posedge clk_i) begin
        if (enter_resp && req_cur.write && !access_err) begin
            mem[idx] <= merged_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        req_valid, req_write, req_sext, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_width;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid1, req_write1, req_sext1, rsp_ready1;
    logic [31:0] req_addr1, req_wdata1;
    logic [1:0]  req_width1;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_width_i(req_width),
        .req_write_i(req_write), .req_sign_extend_i(req_sext),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1),
        .req_addr_i(req_addr1), .req_wdata_i(req_wdata1), .req_width_i(req_width1),
        .req_write_i(req_write1), .req_sign_extend_i(req_sext1),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1),
        .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err1)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge with the responder idle
    task automatic do_req(input string tag, input logic wr, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] d, input logic sx,
                          input int hold, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        req_valid = 1'b1;
        req_write = wr;
        req_width = w;
        req_addr  = a;
        req_wdata = d;
        req_sext  = sx;
        chk1({tag, "_rdy_before"}, req_ready, 1'b1);
        @(posedge clk); #1;
        // scramble inputs: the DUT must have captured them
        req_valid = 1'b0;
        req_write = ~wr;
        req_width = 2'b11;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = ~d;
        req_sext  = ~sx;
        chk1({tag, "_rdy_after_acc"}, req_ready, 1'b0);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk32({tag, "_latency"}, 32'(n), 32'd2);
        for (int i = 0; i < hold; i++) begin
            chk1({tag, "_hold_vld"}, rsp_valid, 1'b1);
            chk32({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
            chk1({tag, "_hold_err"}, rsp_err, exp_err);
            chk1({tag, "_hold_rdy"}, req_ready, 1'b0);
            @(posedge clk); #1;
        end
        chk32({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk1({tag, "_err"}, rsp_err, exp_err);
        chk1({tag, "_rdy_in_resp"}, req_ready, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk1({tag, "_vld_after_hs"}, rsp_valid, 1'b0);
        chk1({tag, "_rdy_after_hs"}, req_ready, 1'b1);
    endtask

    int   last_acc;
    int   nacc;
    logic acc;

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_sext = 0; rsp_ready = 0;
        req_addr = 0; req_wdata = 0; req_width = 0;
        req_valid1 = 0; req_write1 = 0; req_sext1 = 0; rsp_ready1 = 0;
        req_addr1 = 0; req_wdata1 = 0; req_width1 = 0;

        // reset state
        #2;
        chk1("rst_rdy", req_ready, 1'b0);
        chk1("rst_vld", rsp_valid, 1'b0);
        chk32("rst_rdata", rsp_rdata, 32'h0);
        chk1("rst_err", rsp_err, 1'b0);
        chk1("rst_rdy1", req_ready1, 1'b0);
        @(posedge clk); #1;
        chk1("rst_rdy_edge", req_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk1("rel_rdy_pre_edge", req_ready, 1'b0);
        @(posedge clk); #1;
        chk1("rel_rdy_first_edge", req_ready, 1'b1);
        chk1("rel_vld", rsp_valid, 1'b0);

        // word store / load
        do_req("st_w10",   1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 1'b0);
        do_req("ld_w10",   1'b0, 2'b10, 32'h10, 32'h0,         1'b0, 0, 32'hDEAD_BEEF, 1'b0);
        // byte store over the word, upper wdata bits must be ignored
        do_req("st_b13",   1'b1, 2'b00, 32'h13, 32'h1234_5680, 1'b0, 0, 32'h0, 1'b0);
        do_req("ld_b13s",  1'b0, 2'b00, 32'h13, 32'h0,         1'b1, 0, 32'hFFFF_FF80, 1'b0);
        do_req("ld_w10u",  1'b0, 2'b10, 32'h10, 32'h0,         1'b0, 0, 32'h80AD_BEEF, 1'b0);
        do_req("ld_b13u",  1'b0, 2'b00, 32'h13, 32'h0,         1'b0, 0, 32'h0000_0080, 1'b0);
        do_req("ld_b11s",  1'b0, 2'b00, 32'h11, 32'h0,         1'b1, 0, 32'hFFFF_FFBE, 1'b0);
        do_req("ld_h12s",  1'b0, 2'b01, 32'h12, 32'h0,         1'b1, 0, 32'hFFFF_80AD, 1'b0);
        do_req("ld_h12u",  1'b0, 2'b01, 32'h12, 32'h0,         1'b0, 0, 32'h0000_80AD, 1'b0);
        // half store to lane 0
        do_req("st_h10",   1'b1, 2'b01, 32'h10, 32'hFFFF_1234, 1'b0, 0, 32'h0, 1'b0);
        do_req("ld_w10b",  1'b0, 2'b10, 32'h10, 32'h0,         1'b0, 0, 32'h80AD_1234, 1'b0);

        // error cases
        do_req("ld_h11",   1'b0, 2'b01, 32'h11,  32'h0,        1'b1, 0, 32'h0, 1'b1);
        do_req("st_w400",  1'b1, 2'b10, 32'h400, 32'h5555_AAAA, 1'b0, 0, 32'h0, 1'b1);
        do_req("ld_w400",  1'b0, 2'b10, 32'h400, 32'h0,        1'b0, 0, 32'h0, 1'b1);
        do_req("ld_rsvd",  1'b0, 2'b11, 32'h10,  32'h0,        1'b0, 0, 32'h0, 1'b1);
        do_req("st_w12",   1'b1, 2'b10, 32'h12,  32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b1);
        do_req("st_h11",   1'b1, 2'b01, 32'h11,  32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b1);
        do_req("ld_w10c",  1'b0, 2'b10, 32'h10,  32'h0,        1'b0, 0, 32'h80AD_1234, 1'b0);

        // backpressure: hold response for 5 cycles
        do_req("bp_w10",   1'b0, 2'b10, 32'h10,  32'h0,        1'b0, 5, 32'h80AD_1234, 1'b0);

        // reset while BUSY abandons a store
        do_req("st_w20z",  1'b1, 2'b10, 32'h20,  32'h0,        1'b0, 0, 32'h0, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_width = 2'b10;
        req_addr = 32'h20; req_wdata = 32'h1234_5678; req_sext = 1'b0;
        chk1("rstbusy_rdy_before", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk1("rstbusy_rdy_acc", req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("rstbusy_vld", rsp_valid, 1'b0);
        chk1("rstbusy_rdy", req_ready, 1'b0);
        chk32("rstbusy_rdata", rsp_rdata, 32'h0);
        chk1("rstbusy_err", rsp_err, 1'b0);
        @(posedge clk); #1;
        chk1("rstbusy_vld_edge", rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("rstbusy_rdy_rel", req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk1("rstbusy_no_rsp", rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
        do_req("ld_w20",   1'b0, 2'b10, 32'h20,  32'h0,        1'b0, 0, 32'h0, 1'b0);

        // LATENCY=1 instance: back-to-back loads held valid
        req_valid1 = 1'b1; req_write1 = 1'b0; req_width1 = 2'b10;
        req_addr1 = 32'h4; req_sext1 = 1'b0; rsp_ready1 = 1'b1;
        last_acc = -1;
        nacc = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            acc = req_ready1;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                chk1("l1_rsp_after_1", rsp_valid1, 1'b1);
                chk1("l1_err", rsp_err1, 1'b0);
                chk1("l1_rdy_in_resp", req_ready1, 1'b0);
                if (last_acc >= 0) begin
                    chk32("l1_acc_gap", 32'(cyc - last_acc), 32'd2);
                end
                last_acc = cyc;
            end
        end
        chk32("l1_nacc", 32'(nacc), 32'd6);
        req_valid1 = 1'b0;
        rsp_ready1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the storage size in 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to response valid; legal range 1..15.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_i, input, 1 bit: the CPU presents a memory request.
REQ-006 SHALL have port req_ready_o, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-008 SHALL have port req_wdata_i, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port req_width_i, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port req_write_i, input, 1 bit: 1 for store, 0 for load.
REQ-011 SHALL have port req_sign_extend_i, input, 1 bit: sign-extend load data (1) or zero-extend it (0).
REQ-012 SHALL have port rsp_valid_o, output, 1 bit: a response is available.
REQ-013 SHALL have port rsp_ready_i, input, 1 bit: the CPU accepts the response.
REQ-014 SHALL have port rsp_rdata_o, output, 32 bits: load result; 0 for stores and errors.
REQ-015 SHALL have port rsp_err_o, output, 1 bit: the request was misaligned, out of range or of reserved width.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and RESP.
- IDLE -> BUSY on req_valid_i & req_ready_o.
- BUSY -> RESP when the countdown reaches 0.
- RESP -> IDLE on rsp_valid_o & rsp_ready_i.
REQ-017 SHALL drive req_ready_o=1 only in IDLE, and rsp_valid_o=1 only in RESP.
REQ-018 SHALL capture all request fields into registers at the acceptance edge; inputs are don't-care afterwards.
REQ-019 SHALL load the countdown with LATENCY-1 at acceptance and decrement it by 1 per cycle in BUSY.
- With LATENCY=1, the FSM passes through BUSY for 0 cycles, so rsp_valid_o rises 1 cycle after acceptance.
- In general, rsp_valid_o is first high LATENCY cycles after the acceptance edge.
REQ-020 SHALL flag an error for any of the following; on error, memory is not written, rsp_rdata_o=0 and rsp_err_o=1:
- width 11;
- half access with addr[0]≠0;
- word access with addr[1:0]≠0;
- word index addr[31:2] ≥ DEPTH_WORDS.
REQ-021 SHALL use little-endian byte lanes, with lane = addr[1:0].
- A store updates only the addressed byte or half lanes of the word and leaves other lanes unchanged.
REQ-022 SHALL commit stores, and sample load data, on the edge entering RESP.
REQ-023 SHALL hold rsp_rdata_o and rsp_err_o stable while rsp_valid_o=1 and rsp_ready_i=0 (backpressure of any length).
REQ-024 SHALL place a loaded byte or half at rdata[7:0] or [15:0], with upper bits sign- or zero-extended per the captured sign_extend; a word load returns all 32 bits.
REQ-025 SHALL not accept a new request in the same cycle as a response handshake; req_ready_o returns to 1 the cycle after the handshake (one request in flight, at most one accepted per 2 cycles with LATENCY=1).
REQ-026 SHALL make a load issued after a completed store to the same address return the stored data.

Reset
REQ-027 SHALL, while rst_i=0, force state to IDLE, countdown to 0, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0 and rsp_err_o=0.
REQ-028 SHALL drive req_ready_o=1 on the first edge after rst_i deasserts.
REQ-029 SHALL leave storage contents uninitialised by reset.
REQ-030 SHALL abandon any request in flight when reset asserts mid-operation (BUSY or RESP): the pending store is not committed and no response is issued after reset.

Structure
REQ-031 SHALL place the width encodings (BYTE/HALF/WORD/RSVD), the FSM state encoding and the counter width constant in shared package dmem_pkg.
REQ-032 SHALL implement lane alignment (store merge and load extract/extend) in a combinational sub-module mem_lane_align, instantiated once.

Verification
REQ-033 SHALL cover: word store to 0x10 with data 0xDEADBEEF, then word load from 0x10 -> rdata 0xDEADBEEF, err 0, with rsp_valid_o high exactly 2 cycles after each acceptance.
REQ-034 SHALL cover: byte store of 0x80 to 0x13 over that word, then signed byte load from 0x13 -> 0xFFFFFF80, and unsigned word load from 0x10 -> 0x80ADBEEF.
REQ-035 SHALL cover: half load from 0x11 -> err 1, rdata 0; word store to 0x400 (index 256) -> err 1, and a following load from 0x400 -> err 1.
REQ-036 SHALL cover: response held with rsp_ready_i=0 for 5 cycles -> rsp_valid_o, rdata and err stable; req_ready_o=0 throughout; req_ready_o=1 the cycle after the handshake.
REQ-037 SHALL cover: rst_i asserted in BUSY during a word store of 0x12345678 to 0x20 (prior contents 0x0) -> no response; a later load from 0x20 -> 0x00000000.
REQ-038 SHALL cover: LATENCY=1 build with back-to-back loads held valid -> each response 1 cycle after acceptance, acceptances 2 cycles apart.
